// File: rtl/nn_frame_loader_if.sv
// Pin-side byte bus and shadow-register write port of the frame loader.
interface nn_frame_loader_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned ERR_W  = 2;

    logic [DATA_W-1:0] data_in;
    logic              strobe;
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              param_commit;
    logic              input_commit;
    logic              busy;
    logic [ERR_W-1:0]  err_code;

    modport master (
        output data_in, strobe,
        input  wr_en, wr_sel, wr_addr, wr_data, param_commit, input_commit, busy, err_code
    );

    modport slave (
        input  data_in, strobe,
        output wr_en, wr_sel, wr_addr, wr_data, param_commit, input_commit, busy, err_code
    );
endinterface

// File: rtl/nn_frame_loader.sv
// Parses strobed pin bytes into header/payload[/checksum] frames and writes shadow registers.
// Optional feature: define NN_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module nn_frame_loader #(
    parameter int unsigned PARAM_BYTES    = 24,
    parameter int unsigned INPUT_BYTES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input logic              clk,
    input logic              rst_n,
    nn_frame_loader_if.slave bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned ERR_W  = 2;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DATA_W-1:0] HDR_PARAM   = 8'hA5;
    localparam logic [DATA_W-1:0] HDR_INPUT   = 8'h5A;
    localparam logic [ADDR_W-1:0] PARAM_LAST  = ADDR_W'(PARAM_BYTES - 1);
    localparam logic [ADDR_W-1:0] INPUT_LAST  = ADDR_W'(INPUT_BYTES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ERR_W-1:0]  ERR_NONE    = 2'd0;
    localparam logic [ERR_W-1:0]  ERR_HEADER  = 2'd1;
    localparam logic [ERR_W-1:0]  ERR_TIMEOUT = 2'd3;
`ifdef NN_LOADER_CHECKSUM_EN
    localparam logic [ERR_W-1:0]  ERR_CSUM    = 2'd2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD
`ifdef NN_LOADER_CHECKSUM_EN
        , ST_CHECK
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                strobe_prev_q;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                wr_en_q, wr_en_d;
    logic                wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                param_commit_q, param_commit_d;
    logic                input_commit_q, input_commit_d;
    logic                busy_q, busy_d;
    logic [ERR_W-1:0]    err_q, err_d;
`ifdef NN_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   acc_q, acc_d;
`else
    logic                commit_pend_q, commit_pend_d;
`endif

    logic              byte_c;
    logic              tmo_expire_c;
    logic [ADDR_W-1:0] last_c;

    assign byte_c       = sync_q[SYNC_STAGES-1] & ~strobe_prev_q;
    assign tmo_expire_c = (tmo_q == TMO_LAST);
    assign last_c       = wr_sel_q ? INPUT_LAST : PARAM_LAST;

    // State and output registers, including the strobe synchroniser.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            sync_q         <= '0;
            strobe_prev_q  <= 1'b0;
            cnt_q          <= '0;
            tmo_q          <= '0;
            wr_en_q        <= 1'b0;
            wr_sel_q       <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            param_commit_q <= 1'b0;
            input_commit_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= ERR_NONE;
`ifdef NN_LOADER_CHECKSUM_EN
            acc_q          <= '0;
`else
            commit_pend_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            sync_q[0]      <= bus.strobe;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            strobe_prev_q  <= sync_q[SYNC_STAGES-1];
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            wr_en_q        <= wr_en_d;
            wr_sel_q       <= wr_sel_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            param_commit_q <= param_commit_d;
            input_commit_q <= input_commit_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
`ifdef NN_LOADER_CHECKSUM_EN
            acc_q          <= acc_d;
`else
            commit_pend_q  <= commit_pend_d;
`endif
        end
    end

    // Frame parser: next state and next registered outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        wr_en_d        = 1'b0;
        wr_sel_d       = wr_sel_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        param_commit_d = 1'b0;
        input_commit_d = 1'b0;
        err_d          = err_q;
`ifdef NN_LOADER_CHECKSUM_EN
        acc_d          = acc_q;
`else
        commit_pend_d  = 1'b0;
        // Commit trails the last payload write by one cycle.
        if (commit_pend_q) begin
            param_commit_d = ~wr_sel_q;
            input_commit_d = wr_sel_q;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (byte_c) begin
                    if (bus.data_in == HDR_PARAM || bus.data_in == HDR_INPUT) begin
                        state_d  = ST_PAYLOAD;
                        wr_sel_d = (bus.data_in == HDR_INPUT);
                        cnt_d    = '0;
                        tmo_d    = '0;
                        err_d    = ERR_NONE;
`ifdef NN_LOADER_CHECKSUM_EN
                        acc_d    = '0;
`endif
                    end else begin
                        err_d = ERR_HEADER;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_c) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = bus.data_in;
                    tmo_d     = '0;
`ifdef NN_LOADER_CHECKSUM_EN
                    acc_d     = acc_q ^ bus.data_in;
`endif
                    if (cnt_q == last_c) begin
`ifdef NN_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d       = ST_IDLE;
                        commit_pend_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end else if (tmo_expire_c) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`ifdef NN_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_c) begin
                    state_d = ST_IDLE;
                    if (bus.data_in == acc_q) begin
                        param_commit_d = ~wr_sel_q;
                        input_commit_d = wr_sel_q;
                    end else begin
                        err_d = ERR_CSUM;
                    end
                end else if (tmo_expire_c) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.wr_en        = wr_en_q;
    assign bus.wr_sel       = wr_sel_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.param_commit = param_commit_q;
    assign bus.input_commit = input_commit_q;
    assign bus.busy         = busy_q;
    assign bus.err_code     = err_q;
endmodule
